// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = WIDTH;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        MULT_RUN,
        DIV_RUN,
        FINISH
    } stateT;

    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
        // 0x80000000 maps to itself, which read as unsigned is the true magnitude
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Control-unit <-> multiply/divide sequencer bus. Carries abort only when MULDIV_ABORT_EN is defined.
interface muldiv_if;

    logic                          mult_start;
    logic                          div_start;
    logic [muldiv_pkg::WIDTH-1:0]  op_a;
    logic [muldiv_pkg::WIDTH-1:0]  op_b;
    logic                          busy;
    logic                          done;
    logic                          div_zero;
    logic [muldiv_pkg::WIDTH-1:0]  hi_out;
    logic [muldiv_pkg::WIDTH-1:0]  lo_out;
`ifdef MULDIV_ABORT_EN
    logic                          abort;

    modport master (
        output mult_start, div_start, op_a, op_b, abort,
        input  busy, done, div_zero, hi_out, lo_out
    );
    modport slave (
        input  mult_start, div_start, op_a, op_b, abort,
        output busy, done, div_zero, hi_out, lo_out
    );
`else
    modport master (
        output mult_start, div_start, op_a, op_b,
        input  busy, done, div_zero, hi_out, lo_out
    );
    modport slave (
        input  mult_start, div_start, op_a, op_b,
        output busy, done, div_zero, hi_out, lo_out
    );
`endif

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the datapath: a radix-2 Booth step or one restoring-divide quotient bit.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic             isDiv,
    input  logic [WIDTH:0]   accIn,
    input  logic [WIDTH-1:0] lowIn,
    input  logic             qm1In,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH:0]   accOut,
    output logic [WIDTH-1:0] lowOut,
    output logic             qm1Out
);

    logic [WIDTH:0]   mExt;
    logic [WIDTH:0]   boothSum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        // Guard bit on the accumulator keeps a -2^(WIDTH-1) multiplicand exact
        mExt = {operand[WIDTH-1], operand};
        case ({lowIn[0], qm1In})
            2'b01:   boothSum = accIn + mExt;
            2'b10:   boothSum = accIn - mExt;
            default: boothSum = accIn;
        endcase

        // Divide: acc is the partial remainder, low shifts dividend out and quotient in
        shifted = {accIn[WIDTH-1:0], lowIn[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, operand};

        if (isDiv) begin
            accOut = trial[WIDTH+1] ? shifted : trial[WIDTH:0];
            lowOut = {lowIn[WIDTH-2:0], ~trial[WIDTH+1]};
            qm1Out = 1'b0;
        end else begin
            accOut = {boothSum[WIDTH], boothSum[WIDTH:1]};
            lowOut = {boothSum[0], lowIn[WIDTH-1:1]};
            qm1Out = lowIn[0];
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide controller writing HI/LO for the multicycle MIPS core.
// Optional MULDIV_ABORT_EN adds an abort input that cancels a running operation.
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    muldiv_if.slave  bus
);

    stateT            state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] operand;
    logic             qm1;
    logic             divOp;
    logic             negQuo;
    logic             negRem;
    logic             zeroDiv;
    logic             busyQ;
    logic             doneQ;
    logic             divZeroQ;
    logic [WIDTH-1:0] hiQ;
    logic [WIDTH-1:0] loQ;

    logic [WIDTH:0]   stepAcc;
    logic [WIDTH-1:0] stepLow;
    logic             stepQm1;
    logic [WIDTH-1:0] remMag;

    assign remMag = acc[WIDTH-1:0];

    muldiv_step uStep (
        .isDiv   (state == DIV_RUN),
        .accIn   (acc),
        .lowIn   (low),
        .qm1In   (qm1),
        .operand (operand),
        .accOut  (stepAcc),
        .lowOut  (stepLow),
        .qm1Out  (stepQm1)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            low      <= '0;
            operand  <= '0;
            qm1      <= 1'b0;
            divOp    <= 1'b0;
            negQuo   <= 1'b0;
            negRem   <= 1'b0;
            zeroDiv  <= 1'b0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            divZeroQ <= 1'b0;
            hiQ      <= '0;
            loQ      <= '0;
        end else begin
            doneQ    <= 1'b0;
            divZeroQ <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.mult_start) begin
                        state   <= MULT_RUN;
                        busyQ   <= 1'b1;
                        divOp   <= 1'b0;
                        zeroDiv <= 1'b0;
                        acc     <= '0;
                        low     <= bus.op_b;
                        qm1     <= 1'b0;
                        operand <= bus.op_a;
                    end else if (bus.div_start) begin
                        busyQ   <= 1'b1;
                        divOp   <= 1'b1;
                        negQuo  <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
                        negRem  <= bus.op_a[WIDTH-1];
                        acc     <= '0;
                        low     <= absVal(bus.op_a);
                        qm1     <= 1'b0;
                        operand <= absVal(bus.op_b);
                        if (bus.op_b == '0) begin
                            state   <= FINISH;
                            zeroDiv <= 1'b1;
                        end else begin
                            state   <= DIV_RUN;
                            zeroDiv <= 1'b0;
                        end
                    end
                end
                MULT_RUN, DIV_RUN: begin
                    acc <= stepAcc;
                    low <= stepLow;
                    qm1 <= stepQm1;
                    if (cnt == CNT_W'(ITER - 1)) begin
                        cnt   <= '0;
                        state <= FINISH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`ifdef MULDIV_ABORT_EN
                    if (bus.abort) begin
                        state <= IDLE;
                        busyQ <= 1'b0;
                        cnt   <= '0;
                    end
`endif
                end
                FINISH: begin
                    state    <= IDLE;
                    busyQ    <= 1'b0;
                    doneQ    <= 1'b1;
                    divZeroQ <= zeroDiv;
                    // HI/LO are held across a zero-divide
                    if (!zeroDiv) begin
                        if (divOp) begin
                            hiQ <= negRem ? -remMag : remMag;
                            loQ <= negQuo ? -low : low;
                        end else begin
                            hiQ <= remMag;
                            loQ <= low;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busyQ;
    assign bus.done     = doneQ;
    assign bus.div_zero = divZeroQ;
    assign bus.hi_out   = hiQ;
    assign bus.lo_out   = loQ;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the HI/LO multiply/divide resource in the multicycle MIPS core.
- Accepts single-cycle start pulses from control_unit (its MultCtrl/DivCtrl strobes) together with operands from registers A and B.
- Runs an iterative signed Booth multiply or a signed restoring divide, then writes HI/LO with a completion handshake.
- Reports divide-by-zero to the control unit, which raises the exception.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, WIDTH, iteration count per operation. Fixed equal to WIDTH and not overridden.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- mult_start  in  1  one-cycle request for signed multiply.
- div_start  in  1  one-cycle request for signed divide.
- op_a  in  WIDTH  multiplicand or dividend (register A).
- op_b  in  WIDTH  multiplier or divisor (register B).
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse when the divisor is zero.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0. busy, done, div_zero=0. hi_out=lo_out=0. Operand shadows cleared.
- States: IDLE, MULT_RUN, DIV_RUN, FINISH.
- IDLE:
  - mult_start=1 at edge E0: latch op_a/op_b and go to MULT_RUN.
  - Else div_start=1 with op_b!=0: latch and go to DIV_RUN.
  - div_start=1 with op_b==0: go to FINISH with a zero-divide flag set.
  - If both starts are high, mult_start wins and div_start is dropped.
- Operands are latched at the start edge. Later changes on op_a/op_b have no effect until the next start.
- busy=1 in MULT_RUN, DIV_RUN and FINISH. busy=0 only in IDLE.
- MULT_RUN: radix-2 Booth on a 2*WIDTH+1 product register, one step per cycle. After ITER steps (edges E1..E32) go to FINISH.
- DIV_RUN:
  - Divide magnitudes with a restoring algorithm, one quotient bit per cycle, ITER cycles, then FINISH.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend (truncation toward zero).
- FINISH (one cycle):
  - done=1.
  - On a normal completion, hi_out/lo_out update at the E0+ITER+1 edge (visible in the cycle where done=1). Multiply: {HI,LO}=64-bit product. Divide: LO=quotient, HI=remainder.
  - On a zero-divide: done=1 and div_zero=1 one cycle after E0. hi_out/lo_out are held.
  - Next edge returns to IDLE.
- Latency:
  - Normal operation: done is high in cycle E0+33.
  - Zero-divide: done is high in cycle E0+1.
  - A new start is accepted in the IDLE cycle after FINISH, with no back-to-back overlap.
- Any start pulse while busy is ignored. No queuing, and no error is raised.
- Overflow case 0x80000000 / -1: LO=0x80000000, HI=0. This is wrap-around with no flag.
- HI/LO change only at FINISH on a normal completion. They hold through later idle cycles and through zero-divide.
- Reset asserted mid-operation: immediate return to IDLE with HI/LO=0. The pending done is never issued.

Optional Feature:
- Macro: MULDIV_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in MULT_RUN or DIV_RUN forces IDLE at the next edge. No done, HI/LO unchanged, counter cleared.
  - abort in IDLE or FINISH is ignored.
  - The control unit uses this to cancel an operation on an interrupt.
- Undefined: no abort port, and every accepted operation runs to completion.

Decomposition:
- Package muldiv_pkg: state enum (IDLE, MULT_RUN, DIV_RUN, FINISH), constants WIDTH=32, ITER=32, and counter width CNT_W=6.
- One natural sub-module, muldiv_step: combinational, computes one Booth step or one restoring-divide step from the current partial registers.
- The sequencer owns the FSM, counter, sign fix-up and HI/LO registers.

Test Plan:
- mult: op_a=7, op_b=0xFFFFFFFD (-3) -> done exactly 33 cycles after start edge; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for 33 cycles.
- mult: 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000.
- div: op_a=0xFFFFFFF9 (-7), op_b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- div by zero: preload HI=0x11, LO=0x22, then div_start with op_b=0 -> done=div_zero=1 one cycle later; HI/LO remain 0x11/0x22.
- Busy/reset:
  - div_start pulsed at cycle 10 of a running multiply -> ignored; multiply result intact.
  - reset low at cycle 15 of an op -> busy=0 and HI=LO=0 immediately; no done.
- MULDIV_ABORT_EN: abort at cycle 5 of a divide -> IDLE next edge, no done, HI/LO unchanged; a new mult_start is then accepted normally.
